// File: rtl/iomem_timer_pkg.sv
// Shared constants for the iomem_timer peripheral: register offsets (word index),
// CTRL/STATUS bit positions and the prescaler width.
package iomem_timer_pkg;

    localparam int PRESC_W = 16;

    // Offsets are word indices, i.e. iomem_addr[7:2].
    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_PRESC  = 6'h01;
    localparam logic [5:0] REG_COUNT  = 6'h02;
    localparam logic [5:0] REG_CMP    = 6'h03;
    localparam logic [5:0] REG_STATUS = 6'h04;
    localparam logic [5:0] REG_CAP    = 6'h05;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_CAP_IRQ_EN = 3;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_CAP   = 1;

endpackage

// File: rtl/iomem_timer_sync.sv
// Two-flop synchronizer for an asynchronous strobe, plus a one-cycle pulse on
// each synchronized rising edge.
module iomem_timer_sync (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level.
    logic [2:0] sync_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], din};
        end
    end

    assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit prescaled timer with compare match on the iomem bus.
// Define IOMEM_TIMER_CAPTURE_EN to add the capture_in port and the CAP register.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
`ifdef IOMEM_TIMER_CAPTURE_EN
    input  logic        capture_in,
`endif
    output logic        irq
);

`ifdef IOMEM_TIMER_CAPTURE_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] CTRL_WMASK = 4'h7;
`endif

    logic               hit;
    logic               ack;
    logic               unused_addr_bits;
    logic               ready_reg;
    logic [5:0]         offset_reg;
    logic [3:0]         wstrb_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        byte_mask;

    logic [3:0]         ctrl_reg, ctrl_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [PRESC_W-1:0] psc_cnt_reg, psc_cnt_next;
    logic [31:0]        count_reg, count_next;
    logic [31:0]        cmp_reg, cmp_next;
    logic [1:0]         status_reg, status_next;
    logic               irq_reg, irq_next;
    logic [31:0]        rdata_mux;

    logic               wr_en, wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic [3:0]         ctrl_wr;
    logic [PRESC_W-1:0] presc_wr;
    logic [31:0]        count_wr, cmp_wr;
    logic [1:0]         w1c;
    logic               start_wr, stop_wr, run, tick, match;

`ifdef IOMEM_TIMER_CAPTURE_EN
    logic        cap_rise;
    logic [31:0] cap_reg, cap_next;

    iomem_timer_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (capture_in),
        .rise   (cap_rise)
    );
`endif

    assign hit = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    // Blocking on our own ready keeps a held request from being acknowledged twice.
    assign ack = hit && !ready_reg;
    assign unused_addr_bits = ^iomem_addr[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_reg  <= 1'b0;
            offset_reg <= '0;
            wstrb_reg  <= '0;
            wdata_reg  <= '0;
        end else begin
            ready_reg <= ack;
            if (ack) begin
                offset_reg <= iomem_addr[7:2];
                wstrb_reg  <= iomem_wstrb;
                wdata_reg  <= iomem_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_mask[8*gi +: 8] = {8{wstrb_reg[gi]}};
    end

    // Writes commit at the edge closing the acknowledge cycle.
    assign wr_en     = ready_reg && (wstrb_reg != 4'd0);
    assign wr_ctrl   = wr_en && (offset_reg == REG_CTRL);
    assign wr_presc  = wr_en && (offset_reg == REG_PRESC);
    assign wr_count  = wr_en && (offset_reg == REG_COUNT);
    assign wr_cmp    = wr_en && (offset_reg == REG_CMP);
    assign wr_status = wr_en && (offset_reg == REG_STATUS);

    assign ctrl_wr  = ((ctrl_reg & ~byte_mask[3:0]) | (wdata_reg[3:0] & byte_mask[3:0])) & CTRL_WMASK;
    assign presc_wr = (presc_reg & ~byte_mask[PRESC_W-1:0]) | (wdata_reg[PRESC_W-1:0] & byte_mask[PRESC_W-1:0]);
    assign count_wr = (count_reg & ~byte_mask) | (wdata_reg & byte_mask);
    assign cmp_wr   = (cmp_reg & ~byte_mask) | (wdata_reg & byte_mask);
    assign w1c      = wdata_reg[1:0] & byte_mask[1:0];

    assign start_wr = wr_ctrl && ctrl_wr[CTRL_EN] && !ctrl_reg[CTRL_EN];
    assign stop_wr  = wr_ctrl && !ctrl_wr[CTRL_EN];
    // A CPU write clearing EN suppresses the tick of that same cycle.
    assign run      = ctrl_reg[CTRL_EN] && !stop_wr;
    assign tick     = run && (psc_cnt_reg == presc_reg);
    assign match    = (count_reg == cmp_reg);

    always_comb begin
        ctrl_next    = ctrl_reg;
        presc_next   = presc_reg;
        psc_cnt_next = psc_cnt_reg;
        count_next   = count_reg;
        cmp_next     = cmp_reg;
        status_next  = status_reg;

        if (wr_ctrl)   ctrl_next   = ctrl_wr;
        if (wr_presc)  presc_next  = presc_wr;
        if (wr_cmp)    cmp_next    = cmp_wr;
        if (wr_status) status_next = status_reg & ~w1c;

        if (start_wr) begin
            psc_cnt_next = '0;
        end else if (run) begin
            psc_cnt_next = tick ? '0 : psc_cnt_reg + 1'b1;
        end

        // Event sets are applied after the W1C so they win a same-cycle clear.
        if (tick) begin
            if (match) begin
                status_next[STATUS_MATCH] = 1'b1;
                if (ctrl_reg[CTRL_AUTORELOAD]) begin
                    count_next = '0;
                end else begin
                    ctrl_next[CTRL_EN] = 1'b0;
                end
            end else begin
                count_next = count_reg + 32'd1;
            end
        end

        if (wr_count) count_next = count_wr;
    end

`ifdef IOMEM_TIMER_CAPTURE_EN
    always_comb begin
        cap_next = cap_reg;
        if (cap_rise) cap_next = count_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_reg <= '0;
        end else begin
            cap_reg <= cap_next;
        end
    end

    assign irq_next = (status_reg[STATUS_MATCH] & ctrl_reg[CTRL_IRQ_EN])
                    | (status_reg[STATUS_CAP] & ctrl_reg[CTRL_CAP_IRQ_EN]);
`else
    assign irq_next = status_reg[STATUS_MATCH] & ctrl_reg[CTRL_IRQ_EN];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_reg    <= '0;
            presc_reg   <= '0;
            psc_cnt_reg <= '0;
            count_reg   <= '0;
            cmp_reg     <= '0;
            status_reg  <= '0;
            irq_reg     <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            presc_reg   <= presc_next;
            psc_cnt_reg <= psc_cnt_next;
            count_reg   <= count_next;
            cmp_reg     <= cmp_next;
`ifdef IOMEM_TIMER_CAPTURE_EN
            status_reg  <= {status_next[1] | cap_rise, status_next[0]};
`else
            status_reg  <= {1'b0, status_next[0]};
`endif
            irq_reg     <= irq_next;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (offset_reg)
            REG_CTRL:   rdata_mux = {28'd0, ctrl_reg};
            REG_PRESC:  rdata_mux = {{(32-PRESC_W){1'b0}}, presc_reg};
            REG_COUNT:  rdata_mux = count_reg;
            REG_CMP:    rdata_mux = cmp_reg;
            REG_STATUS: rdata_mux = {30'd0, status_reg};
`ifdef IOMEM_TIMER_CAPTURE_EN
            REG_CAP:    rdata_mux = cap_reg;
`endif
            default:    rdata_mux = '0;
        endcase
    end

    assign iomem_ready = ready_reg;
    assign iomem_rdata = ready_reg ? rdata_mux : 32'd0;
    assign irq         = irq_reg;

endmodule
